// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// operation encodings, lookahead group width and the parameter legality rule.
package cla_pipe_adder_pkg;

  localparam int unsigned GROUP_W = 4;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ADDC = 2'b10,
    MODE_SUBB = 2'b11
  } mode_e;

  // WIDTH must be a positive multiple of GROUP_W and STAGES must divide the group count.
  function automatic bit cfg_legal(input int unsigned width, input int unsigned stages);
    if (width < GROUP_W || (width % GROUP_W) != 0 || stages == 0) return 1'b0;
    return ((width / GROUP_W) % stages) == 0;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit lookahead group: three internal carries plus group
// propagate/generate for the next lookahead level.
module cla_group4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [2:0] c,
  output logic       pg,
  output logic       gg
);

  // Separate assigns keep pg/gg visibly independent of cin.
  assign c[0] = g[0] | (p[0] & cin);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one slice of lookahead groups is
// resolved per stage, with a bubble-collapsing valid/ready pipeline.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NG  = WIDTH / GROUP_W;
  localparam int unsigned GPS = NG / STAGES;
  localparam int unsigned SW  = GPS * GROUP_W;
  localparam int unsigned L   = STAGES - 1;

  if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_err
    $error("cla_pipe_adder: illegal WIDTH/STAGES combination");
  end

  // Carry into group hi, given carry cin into group lo, as a flat sum of products.
  function automatic logic la_carry(input logic [NG-1:0] pv, input logic [NG-1:0] gv,
                                    input logic cin, input int unsigned lo,
                                    input int unsigned hi);
    logic acc;
    logic term;
    term = cin;
    for (int unsigned m = 0; m < NG; m++) begin
      if (m >= lo && m < hi) term = term & pv[m];
    end
    acc = term;
    for (int unsigned m = 0; m < NG; m++) begin
      if (m >= lo && m < hi) begin
        term = gv[m];
        for (int unsigned n = 0; n < NG; n++) begin
          if (n > m && n < hi) term = term & pv[n];
        end
        acc = acc | term;
      end
    end
    return acc;
  endfunction

  logic [WIDTH-1:0] bx;
  logic             c0;

  always_comb begin
    bx = b;
    c0 = 1'b0;
    unique case (mode_e'(mode))
      MODE_ADD:  begin bx = b;  c0 = 1'b0; end
      MODE_SUB:  begin bx = ~b; c0 = 1'b1; end
      MODE_ADDC: begin bx = b;  c0 = ci;   end
      MODE_SUBB: begin bx = ~b; c0 = ci;   end
    endcase
  end

  // Inputs seen by each slice: conditioned operands for slice 0, previous register otherwise.
  logic             st_v_in   [STAGES];
  logic [WIDTH-1:0] st_p_in   [STAGES];
  logic [WIDTH-1:0] st_g_in   [STAGES];
  logic [WIDTH-1:0] st_sum_in [STAGES];
  logic             st_c_in   [STAGES];
  logic             st_as_in  [STAGES];
  logic             st_bs_in  [STAGES];

  logic             valid_q [STAGES];
  logic             c_q     [STAGES];
  logic [WIDTH-1:0] p_q     [STAGES];
  logic [WIDTH-1:0] g_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             as_q    [STAGES];
  logic             bs_q    [STAGES];
  logic             zero_q;

  logic [NG-1:0]     pp;
  logic [NG-1:0]     gg;
  logic [NG-1:0]     cgrp;
  logic [WIDTH-1:0]  new_sum;
  logic [STAGES-1:0] slc_co;
  logic [WIDTH-1:0]  sum_nx [STAGES];
  logic [STAGES-1:0] rdy;

  // Stage k can take a beat unless it and every stage after it are full and the sink stalls.
  always_comb begin
    logic full;
    for (int unsigned k = 0; k < STAGES; k++) begin
      full = 1'b1;
      for (int unsigned j = 0; j < STAGES; j++) begin
        if (j >= k) full = full & valid_q[j];
      end
      rdy[k] = out_ready | ~full;
    end
  end

  for (genvar j = 0; j < NG; j++) begin : g_grp
    localparam int unsigned S = j / GPS;
    logic [2:0] c_int;

    cla_group4 u_grp (
      .p   (st_p_in[S][GROUP_W*j +: GROUP_W]),
      .g   (st_g_in[S][GROUP_W*j +: GROUP_W]),
      .cin (cgrp[j]),
      .c   (c_int),
      .pg  (pp[j]),
      .gg  (gg[j])
    );

    assign cgrp[j] = la_carry(pp, gg, st_c_in[S], S * GPS, j);
    assign new_sum[GROUP_W*j +: GROUP_W] = st_p_in[S][GROUP_W*j +: GROUP_W] ^ {c_int, cgrp[j]};
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * SW;

    if (s == 0) begin : g_in
      assign st_v_in[s]   = in_valid;
      assign st_p_in[s]   = a ^ bx;
      assign st_g_in[s]   = a & bx;
      assign st_c_in[s]   = c0;
      assign st_sum_in[s] = '0;
      assign st_as_in[s]  = a[WIDTH-1];
      assign st_bs_in[s]  = bx[WIDTH-1];
    end else begin : g_fwd
      assign st_v_in[s]   = valid_q[s-1];
      assign st_p_in[s]   = p_q[s-1];
      assign st_g_in[s]   = g_q[s-1];
      assign st_c_in[s]   = c_q[s-1];
      assign st_sum_in[s] = sum_q[s-1];
      assign st_as_in[s]  = as_q[s-1];
      assign st_bs_in[s]  = bs_q[s-1];
    end

    // Merge this slice's freshly resolved sum bits over the ones already produced.
    always_comb begin
      sum_nx[s] = st_sum_in[s];
      sum_nx[s][LO +: SW] = new_sum[LO +: SW];
    end

    assign slc_co[s] = la_carry(pp, gg, st_c_in[s], s * GPS, (s + 1) * GPS);

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[s] <= 1'b0;
        c_q[s]     <= 1'b0;
        p_q[s]     <= '0;
        g_q[s]     <= '0;
        sum_q[s]   <= '0;
        as_q[s]    <= 1'b0;
        bs_q[s]    <= 1'b0;
      end else if (rdy[s]) begin
        valid_q[s] <= st_v_in[s];
        // Payload only moves with a real beat, so a bubble never disturbs held data.
        if (st_v_in[s]) begin
          c_q[s]   <= slc_co[s];
          p_q[s]   <= st_p_in[s];
          g_q[s]   <= st_g_in[s];
          sum_q[s] <= sum_nx[s];
          as_q[s]  <= st_as_in[s];
          bs_q[s]  <= st_bs_in[s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (rdy[L] && st_v_in[L]) begin
      zero_q <= (sum_nx[L] == '0);
    end
  end

  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = valid_q[L];
  assign sum       = sum_q[L];
  assign co        = c_q[L];
  assign ovf       = (as_q[L] == bs_q[L]) && (sum_q[L][WIDTH-1] != as_q[L]);
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: four adder configurations share one stimulus stream, each
// with its own scoreboard fed by an arithmetic reference model.
module tb_cla_pipe_adder;
  import cla_pipe_adder_pkg::*;

  typedef struct packed {
    logic [63:0] sum;
    logic        co;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        ci_in;
  logic [1:0]  mode_in;
  logic [63:0] a_in;
  logic [63:0] b_in;

  logic        ir    [4];
  logic        ov    [4];
  logic        oco   [4];
  logic        oovf  [4];
  logic        ozero [4];
  logic [63:0] osum  [4];

  logic [15:0] s0;
  logic [15:0] s1;
  logic [31:0] s2;
  logic [63:0] s3;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int          emits [4];
  int unsigned emit_cyc0 [$];
  exp_t        sb [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign osum[0] = {48'd0, s0};
  assign osum[1] = {48'd0, s1};
  assign osum[2] = {32'd0, s2};
  assign osum[3] = s3;

  cla_pipe_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a_in[15:0]),
    .b(b_in[15:0]), .ci(ci_in), .mode(mode_in), .out_valid(ov[0]), .out_ready(out_ready),
    .sum(s0), .co(oco[0]), .ovf(oovf[0]), .zero(ozero[0])
  );

  cla_pipe_adder #(.WIDTH(16), .STAGES(1)) u_dut_16x1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a_in[15:0]),
    .b(b_in[15:0]), .ci(ci_in), .mode(mode_in), .out_valid(ov[1]), .out_ready(out_ready),
    .sum(s1), .co(oco[1]), .ovf(oovf[1]), .zero(ozero[1])
  );

  cla_pipe_adder #(.WIDTH(32), .STAGES(2)) u_dut_32x2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a_in[31:0]),
    .b(b_in[31:0]), .ci(ci_in), .mode(mode_in), .out_valid(ov[2]), .out_ready(out_ready),
    .sum(s2), .co(oco[2]), .ovf(oovf[2]), .zero(ozero[2])
  );

  cla_pipe_adder #(.WIDTH(64), .STAGES(8)) u_dut_64x8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a_in),
    .b(b_in), .ci(ci_in), .mode(mode_in), .out_valid(ov[3]), .out_ready(out_ready),
    .sum(s3), .co(oco[3]), .ovf(oovf[3]), .zero(ozero[3])
  );

  function automatic int width_of(input int i);
    case (i)
      0, 1:    return 16;
      2:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic civ, input logic [1:0] m);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bxm;
    logic        cin;
    exp_t        e;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = av & mask;
    case (m)
      2'b00:   begin bxm = bv & mask;  cin = 1'b0; end
      2'b01:   begin bxm = ~bv & mask; cin = 1'b1; end
      2'b10:   begin bxm = bv & mask;  cin = civ;  end
      default: begin bxm = ~bv & mask; cin = civ;  end
    endcase
    full   = {1'b0, am} + {1'b0, bxm} + {64'd0, cin};
    e.sum  = full[63:0] & mask;
    e.co   = full[w];
    e.ovf  = (am[w-1] == bxm[w-1]) && (e.sum[w-1] != am[w-1]);
    e.zero = (e.sum == 64'd0);
    return e;
  endfunction

  // Scoreboard: a pending result must be presented unchanged until it is taken.
  always @(negedge clk) begin : p_mon
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 4; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ov[i]) begin
          checks++;
          if (sb[i].size() == 0) begin
            failures++;
            $display("FAIL unexpected_out dut%0d: got out_valid=1 sum=%h, required no result",
                     i, osum[i]);
          end else begin
            e = sb[i][0];
            if (osum[i] !== e.sum || oco[i] !== e.co || oovf[i] !== e.ovf
                || ozero[i] !== e.zero) begin
              failures++;
              $display("FAIL result dut%0d: got sum=%h co=%b ovf=%b zero=%b, required sum=%h co=%b ovf=%b zero=%b",
                       i, osum[i], oco[i], oovf[i], ozero[i], e.sum, e.co, e.ovf, e.zero);
            end
            if (out_ready) begin
              void'(sb[i].pop_front());
              emits[i]++;
              if (i == 0) emit_cyc0.push_back(cyc);
            end
          end
        end
        if (in_valid && ir[i]) sb[i].push_back(model(width_of(i), a_in, b_in, ci_in, mode_in));
      end
    end
  end

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0 && sb[3].size() == 0
          && !ov[0] && !ov[1] && !ov[2] && !ov[3]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a_in = 64'h1234_5678_9abc_def0; b_in = 64'h1; ci_in = 1'b0; mode_in = MODE_ADD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ir[i] !== 1'b0) begin
        failures++; $display("FAIL rst_in_ready dut%0d: got %b, required 0", i, ir[i]);
      end
      checks++;
      if (ov[i] !== 1'b0) begin
        failures++; $display("FAIL rst_out_valid dut%0d: got %b, required 0", i, ov[i]);
      end
    end
    checks++;
    if ({osum[0], oco[0], oovf[0], ozero[0]} !== 67'd0) begin
      failures++;
      $display("FAIL rst_outputs: got sum=%h co=%b ovf=%b zero=%b, required all 0",
               osum[0], oco[0], oovf[0], ozero[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b1) begin
      failures++; $display("FAIL rst_release_ready: got %b, required 1", ir[0]);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [1:0]  tm [4];
    logic        tc [4];
    logic [15:0] es [4];
    logic        eco [4];
    logic        eov [4];
    logic        ez [4];
    int          lat;
    bit          ok;
    ta = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h00FF};
    tb = '{16'h0001, 16'h0001, 16'h0007, 16'h0F00};
    tm = '{MODE_ADD, MODE_ADD, MODE_SUB, MODE_ADDC};
    tc = '{1'b1, 1'b1, 1'b0, 1'b1};  // ci must be ignored for ADD and SUB
    es = '{16'h0000, 16'h8000, 16'hFFFE, 16'h1000};
    eco = '{1'b1, 1'b0, 1'b0, 1'b0};
    eov = '{1'b0, 1'b1, 1'b0, 1'b0};
    ez  = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      a_in = {48'd0, ta[k]}; b_in = {48'd0, tb[k]}; mode_in = tm[k]; ci_in = tc[k];
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ir[0] !== 1'b1) begin
        failures++; $display("FAIL dir_accept[%0d]: got in_ready=%b, required 1", k, ir[0]);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (ov[0] !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat != 4) begin
        failures++; $display("FAIL dir_latency[%0d]: got %0d cycles, required 4", k, lat);
      end
      checks++;
      if (s0 !== es[k] || oco[0] !== eco[k] || oovf[0] !== eov[k] || ozero[0] !== ez[k]) begin
        failures++;
        $display("FAIL dir_value[%0d]: got sum=%h co=%b ovf=%b zero=%b, required sum=%h co=%b ovf=%b zero=%b",
                 k, s0, oco[0], oovf[0], ozero[0], es[k], eco[k], eov[k], ez[k]);
      end
      wait_drain(ok);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    emit_cyc0.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
      mode_in = 2'($urandom_range(0, 3)); ci_in = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (ir[0] !== 1'b1) begin
        failures++; $display("FAIL b2b_ready[%0d]: got %b, required 1", k, ir[0]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok || emit_cyc0.size() != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d results (drained=%0d), required 8", emit_cyc0.size(), ok);
    end else begin
      checks++;
      if (emit_cyc0[7] - emit_cyc0[0] != 7) begin
        failures++;
        $display("FAIL b2b_consecutive: got span %0d cycles, required 7",
                 emit_cyc0[7] - emit_cyc0[0]);
      end
    end
  endtask

  task automatic test_backpressure;
    int  acc;
    int  e0;
    bit  took;
    bit  ok;
    acc = 0;
    e0 = emits[0];
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; mode_in = MODE_SUB;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = ir[0];
      if (took) acc++;
      @(posedge clk); #1;
      if (took) begin
        a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
        mode_in = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    checks++;
    if (acc != 4) begin
      failures++; $display("FAIL bp_accepted: got %0d beats, required 4", acc);
    end
    checks++;
    if (ir[0] !== 1'b0) begin
      failures++; $display("FAIL bp_full_ready: got in_ready=%b, required 0", ir[0]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || emits[0] - e0 != 4) begin
      failures++;
      $display("FAIL bp_release: got %0d results (drained=%0d), required 4", emits[0] - e0, ok);
    end
  endtask

  task automatic test_reset_midflight;
    int e0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
      mode_in = MODE_ADD; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    e0 = emits[0];
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ov[i] !== 1'b0) begin
        failures++; $display("FAIL midrst_flush dut%0d: got out_valid=%b, required 0", i, ov[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b1) begin
      failures++; $display("FAIL midrst_ready: got %b, required 1", ir[0]);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (emits[0] != e0) begin
      failures++; $display("FAIL midrst_stale: got %0d emitted, required 0", emits[0] - e0);
    end
  endtask

  task automatic test_random;
    bit ok;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a_in = {$urandom, $urandom};
      b_in = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a_in = {64{1'b1}};
      if ($urandom_range(0, 7) == 0) b_in = a_in;
      ci_in   = 1'($urandom_range(0, 1));
      mode_in = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL random_drain: got pending %0d/%0d/%0d/%0d, required 0/0/0/0",
               sb[0].size(), sb[1].size(), sb[2].size(), sb[3].size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) emits[i] = 0;
    test_reset;
    test_directed;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
